// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter. Stores to DATA are queued in a small FIFO
// and serialized on tx. Software polls STATUS for full/overflow/busy.
module uart_tx_mmio #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wen,
   input  logic        uartSel,
   input  logic        addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        tx,
   output logic        busy,
   output logic        full,
   output logic        overflow
);

   localparam int                PTR_W       = $clog2(FIFO_DEPTH);
   localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
   localparam logic [PTR_W:0]    DEPTH_C     = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state_reg, state_next;
   logic [BAUD_W-1:0] baud_reg, baud_next;
   logic [2:0]        bit_idx_reg, bit_idx_next;
   logic [7:0]        shift_reg, shift_next;
   logic              tx_reg, tx_next;
   logic              overflow_reg, overflow_next;

   logic [7:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]    count_reg, count_next;

   logic data_wr, ctrl_wr, push, pop, fifo_empty;
   logic [7:0] head;
   logic unused_wdata;

   assign data_wr    = wen & uartSel & ~addr;
   assign ctrl_wr    = wen & uartSel & addr;
   assign fifo_empty = (count_reg == '0);
   assign full       = (count_reg == DEPTH_C);
   assign push       = data_wr & ~full;
   assign head       = fifo_mem[rd_ptr_reg];
   assign unused_wdata = ^wdata[15:8];

   // Storage has no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= wdata[7:0];
   end

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
         2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
         default: count_next = count_reg;
      endcase
   end

   // A dropped byte sets the flag even if a pop frees a slot on the same edge.
   always_comb begin
      overflow_next = overflow_reg;
      if (data_wr && full)
         overflow_next = 1'b1;
      else if (ctrl_wr && wdata[2])
         overflow_next = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         baud_reg    <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         tx_reg      <= 1'b1;
      end else begin
         state_reg   <= state_next;
         baud_reg    <= baud_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
         tx_reg      <= tx_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      baud_next    = baud_reg;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      tx_next      = tx_reg;
      pop          = 1'b0;
      case (state_reg)
         IDLE: begin
            tx_next = 1'b1;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = head;
               baud_next  = BAUD_RELOAD;
               tx_next    = 1'b0;
               state_next = START;
            end
         end
         START: begin
            if (baud_reg == '0) begin
               tx_next      = shift_reg[0];
               baud_next    = BAUD_RELOAD;
               bit_idx_next = 3'd0;
               state_next   = DATA;
            end else begin
               baud_next = baud_reg - BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_reg == '0) begin
               baud_next = BAUD_RELOAD;
               if (bit_idx_reg == 3'd7) begin
                  tx_next    = 1'b1;
                  state_next = STOP;
               end else begin
                  shift_next   = {1'b0, shift_reg[7:1]};
                  tx_next      = shift_reg[1];
                  bit_idx_next = bit_idx_reg + 3'd1;
               end
            end else begin
               baud_next = baud_reg - BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_reg == '0) begin
               // Chain straight into the next start bit when more data is queued.
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = head;
                  baud_next  = BAUD_RELOAD;
                  tx_next    = 1'b0;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_reg - BAUD_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign tx       = tx_reg;
   assign overflow = overflow_reg;
   assign busy     = !fifo_empty || (state_reg != IDLE);
   assign rdata    = addr ? {13'b0, overflow_reg, full, busy} : 16'h0000;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_mmio;

   logic        clk;
   logic        reset;
   logic        wen;
   logic        uartSel;
   logic        addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        tx;
   logic        busy;
   logic        full;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   uart_tx_mmio #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .wen(wen), .uartSel(uartSel), .addr(addr),
      .wdata(wdata), .rdata(rdata), .tx(tx), .busy(busy), .full(full),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected line level at frame position pos (0 start, 1..8 data LSB first, 9 stop).
   function automatic logic frame_bit(input logic [7:0] b, input int pos);
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return b[pos-1];
   endfunction

   task automatic test_reset;
      reset = 1'b1; wen = 1'b0; uartSel = 1'b0; addr = 1'b0; wdata = 16'h0;
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      addr = 1'b1; #1;
      checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h want 0000", rdata); end
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL idle_tx got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
      addr = 1'b0;
      $display("reset: idle state checked");
   endtask

   task automatic test_single;
      logic [7:0] b;
      b = 8'hA5;
      @(negedge clk); wen = 1'b1; uartSel = 1'b1; addr = 1'b0; wdata = 16'h01A5;
      @(negedge clk); wen = 1'b0; uartSel = 1'b0; wdata = 16'h0;
      $display("write DATA 0x01A5");
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_before_pop got %b want 1", tx); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_after_write got %b want 1", busy); end
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (tx !== frame_bit(b, i / 4)) begin
            errors++; $display("FAIL single_frame cycle %0d got %b want %b", i, tx, frame_bit(b, i / 4));
         end
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last_stop got %b want 1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_end got %b want 1", tx); end
      $display("frame 0xa5 observed");
   endtask

   task automatic test_back_to_back;
      fork
         begin : writer
            @(negedge clk); wen = 1'b1; uartSel = 1'b1; addr = 1'b0;
            for (int j = 0; j < 6; j++) begin
               wdata = 16'h0011 + 16'(j);
               @(negedge clk);
               $display("write DATA 0x%h", 8'h11 + 8'(j));
               if (j == 3) begin
                  checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_after_4 got %b want 0", full); end
               end
               if (j == 4) begin
                  checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full_after_5 got %b want 1", full); end
                  checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_after_5 got %b want 0", overflow); end
               end
               if (j == 5) begin
                  checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow_after_6 got %b want 1", overflow); end
               end
            end
            wen = 1'b0; uartSel = 1'b0; wdata = 16'h0; addr = 1'b1; #1;
            checks++; if (rdata !== 16'h0007) begin errors++; $display("FAIL fill_rdata got %h want 0007", rdata); end
            addr = 1'b0;
         end
         begin : monitor
            int wait_n;
            logic [7:0] b;
            wait_n = 0;
            while (tx !== 1'b0 && wait_n < 20) begin
               @(negedge clk); wait_n++;
            end
            checks++;
            if (tx !== 1'b0) begin
               errors++; $display("FAIL fill_start_timeout got tx=%b want 0 within 20 cycles", tx);
            end else begin
               for (int i = 0; i < 200; i++) begin
                  if (i > 0) @(negedge clk);
                  b = 8'h11 + 8'(i / 40);
                  checks++;
                  if (tx !== frame_bit(b, (i % 40) / 4)) begin
                     errors++; $display("FAIL fill_stream cycle %0d got %b want %b", i, tx, frame_bit(b, (i % 40) / 4));
                  end
               end
               @(negedge clk);
               checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_busy_end got %b want 0", busy); end
               checks++; if (tx !== 1'b1) begin errors++; $display("FAIL fill_tx_end got %b want 1", tx); end
               $display("frames 0x11..0x15 observed back-to-back");
            end
         end
      join
   endtask

   task automatic test_ctrl;
      @(negedge clk); wen = 1'b1; uartSel = 1'b1; addr = 1'b1; wdata = 16'h0003;
      @(negedge clk); wen = 1'b0; uartSel = 1'b0;
      $display("write CTRL 0x0003");
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ctrl_keep got %b want 1", overflow); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ctrl_no_push got %b want 0", busy); end
      #1;
      checks++; if (rdata !== 16'h0004) begin errors++; $display("FAIL ctrl_rdata_ovf got %h want 0004", rdata); end
      @(negedge clk); wen = 1'b1; uartSel = 1'b1; addr = 1'b1; wdata = 16'h0004;
      @(negedge clk); wen = 1'b0; uartSel = 1'b0;
      $display("write CTRL 0x0004");
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ctrl_clear got %b want 0", overflow); end
      #1;
      checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL ctrl_rdata_clear got %h want 0000", rdata); end
      @(negedge clk); wen = 1'b1; uartSel = 1'b1; addr = 1'b1; wdata = 16'h0003;
      @(negedge clk); wen = 1'b0; uartSel = 1'b0; addr = 1'b0; wdata = 16'h0;
      $display("write CTRL 0x0003");
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ctrl_stay_clear got %b want 0", overflow); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ctrl_busy got %b want 0", busy); end
   endtask

   task automatic test_ignored;
      @(negedge clk); wen = 1'b1; uartSel = 1'b0; addr = 1'b0; wdata = 16'h0055;
      @(negedge clk); wen = 1'b0;
      $display("write wen-only 0x55");
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL ignored_wen cycle %0d got busy=%b tx=%b want busy=0 tx=1", i, busy, tx);
         end
         @(negedge clk);
      end
      uartSel = 1'b1; wen = 1'b0;
      repeat (2) @(negedge clk);
      uartSel = 1'b0; wdata = 16'h0;
      $display("write sel-only 0x55");
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL ignored_sel cycle %0d got busy=%b tx=%b want busy=0 tx=1", i, busy, tx);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_midframe;
      @(negedge clk); wen = 1'b1; uartSel = 1'b1; addr = 1'b0; wdata = 16'h00F0;
      @(negedge clk); wdata = 16'h003C;
      @(negedge clk); wdata = 16'h000F;
      @(negedge clk); wen = 1'b0; uartSel = 1'b0; wdata = 16'h0;
      $display("write DATA 0xf0, 0x3c, 0x0f");
      // 17 cycles after tx fell: middle of data bit 3 of 0xf0, which is 0
      repeat (16) @(negedge clk);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midframe_bit3 got %b want 0", tx); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b want 1", busy); end
      #2 reset = 1'b1;
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b want 0", busy); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL async_reset_full got %b want 0", full); end
      $display("reset asserted mid-frame");
      @(negedge clk);
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1) begin errors++; $display("FAIL post_reset_tx cycle %0d got %b want 1", i, tx); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_ctrl;
      test_ignored;
      test_reset_midframe;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
